// File: rtl/factorial_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | factorial_pkg : shared state encoding and widths for the factorial engine |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package factorial_pkg;

  localparam int FACT_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MULT  = 3'd2,
    DEC   = 3'd3,
    DONE  = 3'd4
  } fact_state_t;

endpackage
`default_nettype wire

// File: rtl/factorial_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_multiplier : shift-add multiplier, one multiplier bit per cycle,      |
// | fixed N_W-cycle latency after i_start. Rev 1.0                           |
// +--------------------------------------------------------------------------+
module seq_multiplier #(
  parameter int DATA_W = 32,
  parameter int N_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_mcand,
  input  logic [N_W-1:0]        i_mplier,
  output logic [DATA_W+N_W-1:0] o_prod,
  output logic                  o_done
);

  localparam int IDX_W  = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int PROD_W = DATA_W + N_W;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_W - 1);

  logic              r_busy;
  logic [IDX_W-1:0]  r_idx;
  logic [PROD_W-1:0] r_mcand;
  logic [N_W-1:0]    r_mplier;
  logic [PROD_W-1:0] r_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_idx    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_idx    <= '0;
      r_mcand  <= PROD_W'(i_mcand);
      r_mplier <= i_mplier;
      r_prod   <= '0;
    end else if (r_busy) begin
      // Product is wide enough that no partial sum is ever truncated.
      if (r_mplier[r_idx])
        r_prod <= r_prod + (r_mcand << r_idx);
      r_idx <= r_idx + 1'b1;
      if (r_idx == c_last_idx)
        r_busy <= 1'b0;
    end
  end

  assign o_prod = r_prod;
  assign o_done = r_busy && (r_idx == c_last_idx);

endmodule
`default_nettype wire

// File: rtl/subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | subtractor : fixed 32-bit combinational a - b                            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module subtractor (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  assign out = a - b;

endmodule
`default_nettype wire

// File: rtl/factorial_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | factorial_ctrl : iterative n! engine (acc *= cnt, cnt -= 1 until cnt<=1) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module factorial_ctrl
  import factorial_pkg::*;
#(
  parameter int DATA_W = FACT_DATA_W,
  parameter int N_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  localparam int PROD_W = DATA_W + N_W;

  fact_state_t       r_state;
  logic [N_W-1:0]    r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic              r_ovf;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_result;
  logic              r_overflow;

  logic              w_cnt_le1;
  logic              w_mult_start;
  logic              w_mult_done;
  logic [PROD_W-1:0] w_prod;
  logic [31:0]       w_sub_out;
  logic [N_W-1:0]    w_cnt_next;

  assign w_cnt_le1    = (r_cnt <= N_W'(1));
  assign w_mult_start = (r_state == CHECK) && !w_cnt_le1;

  seq_multiplier #(
    .DATA_W (DATA_W),
    .N_W    (N_W)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mult_start),
    .i_mcand  (r_acc),
    .i_mplier (r_cnt),
    .o_prod   (w_prod),
    .o_done   (w_mult_done)
  );

  // cnt is at least 2 whenever DEC runs, so the decrement never wraps.
  subtractor u_sub (
    .a   (32'(r_cnt)),
    .b   (32'd1),
    .out (w_sub_out)
  );
  assign w_cnt_next = w_sub_out[N_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= n_in;
            r_acc   <= DATA_W'(1);
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_cnt_le1) begin
            r_done     <= 1'b1;
            r_result   <= r_acc;
            r_overflow <= r_ovf;
            r_state    <= DONE;
          end else begin
            r_state <= MULT;
          end
        end
        MULT: begin
          if (w_mult_done)
            r_state <= DEC;
        end
        DEC: begin
          r_acc   <= w_prod[DATA_W-1:0];
          r_ovf   <= r_ovf | (|w_prod[PROD_W-1:DATA_W]);
          r_cnt   <= w_cnt_next;
          r_state <= CHECK;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_factorial_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_factorial_ctrl : directed self-checking bench for factorial_ctrl      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_factorial_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  n_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  int n_checks = 0;
  int n_fails  = 0;

  factorial_ctrl #(
    .DATA_W (32),
    .N_W    (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_in     (n_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge. lat is the index of the cycle (counted from the
  // accepting edge k) at whose closing edge done is sampled high; -1 if never.
  task automatic run_op(input logic [4:0] n, input int inj_edge, input logic [4:0] inj_n,
                        output int lat, output logic [31:0] res, output logic ovf,
                        output logic busy_run, output logic busy_after, output logic done_after);
    start = 1'b1;
    n_in  = n;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    n_in     = '0;
    busy_run = busy;
    lat      = -1;
    res      = '0;
    ovf      = 1'b0;
    for (int j = 0; j < 400; j++) begin
      if (done) begin
        lat = j + 1;
        res = result;
        ovf = overflow;
        break;
      end
      if (inj_edge != 0 && j + 1 == inj_edge) begin
        start = 1'b1;
        n_in  = inj_n;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    n_in  = 5'd5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, result, overflow} !== 35'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: busy=%0b done=%0b result=%0d ovf=%0b, want all 0",
               busy, done, result, overflow);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_n5();
    int lat; logic [31:0] res; logic ovf, br, ba, da;
    run_op(5'd5, 0, '0, lat, res, ovf, br, ba, da);
    n_checks++;
    if (lat !== 30) begin n_fails++; $display("FAIL n5_latency: got %0d want 30", lat); end
    n_checks++;
    if (res !== 32'd120) begin n_fails++; $display("FAIL n5_result: got %0d want 120", res); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fails++; $display("FAIL n5_overflow: got %0b want 0", ovf); end
    n_checks++;
    if (br !== 1'b1) begin n_fails++; $display("FAIL n5_busy_running: got %0b want 1", br); end
    n_checks++;
    if (ba !== 1'b0 || da !== 1'b0) begin
      n_fails++; $display("FAIL n5_after_done: busy=%0b done=%0b want 0 0", ba, da);
    end
  endtask

  task automatic test_small();
    int lat; logic [31:0] res; logic ovf, br, ba, da;
    for (int n = 0; n < 2; n++) begin
      run_op(5'(n), 0, '0, lat, res, ovf, br, ba, da);
      n_checks++;
      if (lat !== 2) begin n_fails++; $display("FAIL small_latency n=%0d: got %0d want 2", n, lat); end
      n_checks++;
      if (res !== 32'd1 || ovf !== 1'b0) begin
        n_fails++; $display("FAIL small_result n=%0d: got %0d ovf=%0b want 1 ovf=0", n, res, ovf);
      end
    end
  endtask

  task automatic test_boundary();
    int lat; logic [31:0] res; logic ovf, br, ba, da;
    run_op(5'd12, 0, '0, lat, res, ovf, br, ba, da);
    n_checks++;
    if (res !== 32'h1C8C_FC00 || ovf !== 1'b0 || lat !== 79) begin
      n_fails++; $display("FAIL n12: got %h ovf=%0b lat=%0d want 1c8cfc00 ovf=0 lat=79", res, ovf, lat);
    end
    run_op(5'd13, 0, '0, lat, res, ovf, br, ba, da);
    n_checks++;
    if (res !== 32'h7328_CC00 || ovf !== 1'b1 || lat !== 86) begin
      n_fails++; $display("FAIL n13: got %h ovf=%0b lat=%0d want 7328cc00 ovf=1 lat=86", res, ovf, lat);
    end
    n_checks++;
    if (result !== 32'h7328_CC00 || overflow !== 1'b1) begin
      n_fails++; $display("FAIL n13_held: got %h ovf=%0b want 7328cc00 ovf=1", result, overflow);
    end
    run_op(5'd3, 0, '0, lat, res, ovf, br, ba, da);
    n_checks++;
    if (res !== 32'd6 || ovf !== 1'b0 || lat !== 16) begin
      n_fails++; $display("FAIL n3_after_ovf: got %0d ovf=%0b lat=%0d want 6 ovf=0 lat=16", res, ovf, lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat; logic [31:0] res; logic ovf, br, ba, da;
    run_op(5'd5, 10, 5'd7, lat, res, ovf, br, ba, da);
    n_checks++;
    if (lat !== 30 || res !== 32'd120) begin
      n_fails++; $display("FAIL ignore_start: lat=%0d result=%0d want lat=30 result=120", lat, res);
    end
    n_checks++;
    if (ba !== 1'b0) begin n_fails++; $display("FAIL ignore_start_idle: busy=%0b want 0", ba); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] res; logic ovf, br, ba, da;
    logic saw_done;
    saw_done = 1'b0;
    start = 1'b1;
    n_in  = 5'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (done) saw_done = 1'b1;
      if (j == 14) rst = 1'b1;
      if (j != 14) @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done, result, overflow} !== 35'd0) begin
      n_fails++;
      $display("FAIL abort_outputs: busy=%0b done=%0b result=%0d ovf=%0b want all 0",
               busy, done, result, overflow);
    end
    rst = 1'b0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fails++; $display("FAIL abort_no_done: got 1 want 0"); end
    run_op(5'd4, 0, '0, lat, res, ovf, br, ba, da);
    n_checks++;
    if (res !== 32'd24 || ovf !== 1'b0 || lat !== 23) begin
      n_fails++; $display("FAIL abort_then_n4: got %0d ovf=%0b lat=%0d want 24 ovf=0 lat=23", res, ovf, lat);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    n_in  = '0;
    @(negedge clk);
    test_reset();
    test_n5();
    test_small();
    test_boundary();
    test_ignore_start();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
